// File: rtl/trojan_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trojan_chk_pkg
// Description : Shared types and constants for the response checker:
//               checker state enum, MISR polynomial/seed, and a golden
//               truth-table lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package trojan_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // The lookup takes a table widened to a fixed maximum so that any
  // N_IN up to GOLDEN_IDX_W bits can share one helper.
  localparam int GOLDEN_MAX_W = 256;
  localparam int GOLDEN_IDX_W = 8;

  function automatic logic golden_bit(input logic [GOLDEN_MAX_W-1:0] tbl,
                                      input logic [GOLDEN_IDX_W-1:0] idx);
    return tbl[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/resp_misr.sv
`default_nettype none
// ============================================================================
// Module      : resp_misr
// Description : Serial multiple-input signature register. Shifts one
//               response bit per enabled cycle, feeding back POLY when the
//               outgoing MSB differs from the incoming bit.
// Ports       : CK    - clock, rising edge
//               reset - synchronous active-high, clears signature to 0
//               clr   - load SEED (takes priority over en)
//               en    - shift in din
//               din   - serial response bit
//               sig   - registered signature
// Revision    : 1.0 - initial release
// ============================================================================
module resp_misr
  import trojan_chk_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(MISR_SEED)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge CK) begin
    if (reset) begin
      sig <= '0;
    end else if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ ((sig[SIG_W-1] ^ din) ? POLY : '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/trojan_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : trojan_resp_checker
// Description : Checks (vector, response) pairs from an exhaustive-stimulus
//               run against a golden truth table. Reports sticky fail and
//               order-error flags, mismatch/accept counts, the first failing
//               vector and, when RESP_MISR_EN is defined, a MISR signature
//               of the response stream (otherwise signature is tied to 0).
// Ports       : CK, reset        - clock / synchronous active-high reset
//               start            - one-cycle pulse, begins a run
//               vec_valid        - vec/dut_out pair presented
//               vec, dut_out     - applied vector and DUT response
//               ready            - pairs are accepted (RUN)
//               done             - full table consumed
//               fail, order_err  - sticky mismatch / out-of-order flags
//               mismatch_count   - number of mismatching pairs
//               vec_count        - number of accepted pairs
//               first_fail_vec   - vector of the first mismatch
//               signature        - MISR state
// Revision    : 1.0 - initial release
// ============================================================================
module trojan_resp_checker
  import trojan_chk_pkg::*;
#(
  parameter int                  N_IN   = 5,
  parameter logic [2**N_IN-1:0]  GOLDEN = 32'h6996_9669,
  parameter int                  SIG_W  = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [N_IN-1:0]  vec,
  input  logic             dut_out,
  output logic             ready,
  output logic             done,
  output logic             fail,
  output logic             order_err,
  output logic [N_IN:0]    mismatch_count,
  output logic [N_IN:0]    vec_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [SIG_W-1:0] signature
);

  localparam logic [GOLDEN_MAX_W-1:0] GOLDEN_EXT = GOLDEN_MAX_W'(GOLDEN);
  localparam logic [N_IN:0]           LAST_CNT   = (N_IN+1)'(2**N_IN - 1);

  chk_state_t      state, state_nxt;
  logic            accept;
  logic            start_take;
  logic            mismatch;
  logic [N_IN-1:0] exp_idx;

  // Next-state and strobes. start is only honoured outside RUN, and a
  // vector presented in the same cycle as an honoured start is dropped
  // because accept only exists in RUN.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    start_take = 1'b0;
    mismatch   = dut_out != golden_bit(GOLDEN_EXT, GOLDEN_IDX_W'(vec));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_take = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (vec_valid) begin
          accept = 1'b1;
          if (vec_count == LAST_CNT) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ready/done are registered from the next state so they move together
  // with the state register.
  always_ff @(posedge CK) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge CK) begin
    if (reset || start_take) begin
      vec_count      <= '0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      fail           <= 1'b0;
      order_err      <= 1'b0;
      exp_idx        <= '0;
    end else if (accept) begin
      vec_count <= vec_count + 1'b1;
      exp_idx   <= exp_idx + 1'b1;
      if (vec != exp_idx) order_err <= 1'b1;
      if (mismatch) begin
        mismatch_count <= mismatch_count + 1'b1;
        fail           <= 1'b1;
        // fail still holds its pre-accept value here, so this latches
        // only the first mismatch of the run.
        if (!fail) first_fail_vec <= vec;
      end
    end
  end

`ifdef RESP_MISR_EN
  resp_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(MISR_POLY)),
    .SEED  (SIG_W'(MISR_SEED))
  ) u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (start_take),
    .en    (accept),
    .din   (dut_out),
    .sig   (signature)
  );
`else
  assign signature = '0;
`endif

endmodule
`default_nettype wire
